fpu_dispatcher: RTL and testbench

FPU_DISPATCHER -- requirements
Module: fpu_dispatcher

---
 rtl/fpu_dispatcher.sv | 128 ++++++++++++
 tb/tb_fpu_dispatcher.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fpu_dispatcher.sv
// Sequences one fixed-point operation at a time: accepts a request, issues it to the
// external unit, waits with a bounded timeout, and holds the result until writeback takes it.
//
// state | meaning
// IDLE  | ready for a new request; last operands and result stay on the outputs
// ISSUE | operands driven to the unit for one cycle; fpu_ready is stale and ignored
// WAIT  | waiting for fpu_ready; abandoned with wb_error after TIMEOUT cycles
// DONE  | wb_valid high; result, tag and error held until wb_ready
module fpu_dispatcher #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_operation,
  input  logic [WIDTH-1:0] req_operand_1,
  input  logic [WIDTH-1:0] req_operand_2,
  input  logic [4:0]       req_rd,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_result,
  output logic [4:0]       wb_rd,
  output logic             wb_error,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [1:0]       opc_q, opc_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    rd_d    = rd_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op1_d   = req_operand_1;
          op2_d   = req_operand_2;
          opc_d   = req_operation;
          rd_d    = req_rd;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A ready on the final count still wins over the timeout.
        if (fpu_ready) begin
          res_d   = fpu_result;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign wb_valid      = (state_q == DONE);
  assign fpu_operand_1 = op1_q;
  assign fpu_operand_2 = op2_q;
  assign fpu_operation = opc_q;
  assign wb_result     = res_q;
  assign wb_rd         = rd_q;
  assign wb_error      = err_q;

endmodule

// File: tb/tb_fpu_dispatcher.sv
// Randomized bench for fpu_dispatcher: a mock fixed-point unit answers after a chosen delay
// and each transaction is compared against the expected result, latency and handshakes.
module tb_fpu_dispatcher;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_operation = '0;
  logic [31:0] req_operand_1 = '0;
  logic [31:0] req_operand_2 = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] fpu_operand_1, fpu_operand_2;
  logic [1:0]  fpu_operation;
  logic [31:0] fpu_result;
  logic        fpu_ready = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_error;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  fpu_dispatcher #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_operation(req_operation),
    .req_operand_1(req_operand_1), .req_operand_2(req_operand_2), .req_rd(req_rd),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_error(wb_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mock unit: any distinct function per opcode shows that operands and opcode reach it intact.
  function automatic logic [31:0] mock_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return {a[15:0], a[31:16]} ^ b;
    endcase
  endfunction

  assign fpu_result = mock_fn(fpu_operation, fpu_operand_1, fpu_operand_2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic garbage_req();
    req_valid     = 1'($urandom_range(0, 1));
    req_operation = 2'($urandom);
    req_operand_1 = $urandom;
    req_operand_2 = $urandom;
    req_rd        = 5'($urandom);
  endtask

  // k: WAIT cycle (0-based) where fpu_ready first rises; k >= TO means the unit never answers.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int k, input bit stale, input int bp);
    int          e;
    bit          ok;
    bit          exp_err;
    logic [31:0] exp_res;
    int          exp_lat;
    exp_err = (k >= TO);
    exp_res = exp_err ? 32'h0 : mock_fn(op, a, b);
    exp_lat = exp_err ? TO + 1 : k + 2;

    req_valid = 1'b1; req_operation = op; req_operand_1 = a; req_operand_2 = b; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e  = 0;
    ok = 1'b1;
    while (!wb_valid && e < 300) begin
      if (req_ready !== 1'b0 || busy !== 1'b1 || fpu_operand_1 !== a ||
          fpu_operand_2 !== b || fpu_operation !== op) ok = 1'b0;
      fpu_ready = (e == 0) ? stale : ((e - 1) >= k);
      garbage_req();
      @(posedge clk); #1;
      e++;
    end
    fpu_ready = 1'b0;
    chk("latency", 32'(e), 32'(exp_lat));
    chk("busy_phase_stable", 32'(ok), 32'd1);
    chk("wb_result", wb_result, exp_res);
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    chk("wb_error", 32'(wb_error), 32'(exp_err));

    ok = 1'b1;
    repeat (bp) begin
      garbage_req();
      @(posedge clk); #1;
      if (wb_valid !== 1'b1 || req_ready !== 1'b0 || wb_result !== exp_res ||
          wb_rd !== rd || wb_error !== exp_err || fpu_operand_1 !== a) ok = 1'b0;
    end
    chk("backpressure_hold", 32'(ok), 32'd1);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    req_valid = 1'b0;
    chk("back_to_idle_ready", 32'(req_ready), 32'd1);
    chk("back_to_idle_valid", 32'(wb_valid), 32'd0);
    chk("idle_keeps_operand", fpu_operand_1, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_result"}, wb_result, 32'd0);
    chk({tag, "_wb_error"}, 32'(wb_error), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_fpu_op1"}, fpu_operand_1, 32'd0);
    chk({tag, "_fpu_opc"}, 32'(fpu_operation), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    run_op(2'b00, 32'h0000_0C00, 32'h0000_0400, 5'd5, 0, 1'b1, 0);
    chk("add_value", wb_result, 32'h0000_1000);
    run_op(2'b10, 32'h0000_0040, 32'h0000_0020, 5'd9, 5, 1'b0, 0);
    run_op(2'b11, 32'h1234_5678, 32'h0000_0001, 5'd3, NEVER, 1'b0, 0);
    run_op(2'b01, 32'h0000_0100, 32'h0000_0300, 5'd17, TO - 1, 1'b0, 1);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd31, 3, 1'b1, 10);
    run_op(2'b01, 32'h8000_0000, 32'h0000_0001, 5'd0, TO, 1'b1, 2);

    // Reset in WAIT: immediate abort without any clock edge.
    req_valid = 1'b1; req_operation = 2'b10; req_operand_1 = 32'hDEAD_BEEF;
    req_operand_2 = 32'h0000_0003; req_rd = 5'd12;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    chk("midrst_no_valid", 32'(wb_valid), 32'd0);
    reset = 1'b1;
    run_op(2'b00, 32'h0000_0001, 32'h0000_0001, 5'd7, 1, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      run_op(2'($urandom), $urandom, $urandom, 5'($urandom), int'($urandom_range(0, TO + 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
